// File: rtl/semaforo_pkg.sv
// semaforo_pkg
//   Shared definitions for the two-approach intersection scheduler:
//   lamp codes driven to the light heads, the phase encoding and a helper
//   that maps a phase to the lamp pair shown while in it.
//   Optional feature macro: SEMAFORO_NIGHT_FLASH_EN (adds the FL phase).
package semaforo_pkg;

  localparam logic [1:0] LAMP_OFF    = 2'b00;
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;
  localparam logic [1:0] LAMP_RED    = 2'b11;

  typedef enum logic [2:0] {
    G1  = 3'd0,
    Y1  = 3'd1,
    AR1 = 3'd2,
    G2  = 3'd3,
    Y2  = 3'd4,
    AR2 = 3'd5,
    FL  = 3'd6
  } phase_t;

  // Lamp pair {color, color2} shown in phase ph; flash_off selects the dark
  // half of the night flash.
  function automatic logic [3:0] lamp_pair(input phase_t ph, input logic flash_off);
    logic [3:0] pair;
    case (ph)
      G1:      pair = {LAMP_GREEN,  LAMP_RED};
      Y1:      pair = {LAMP_YELLOW, LAMP_RED};
      AR1:     pair = {LAMP_RED,    LAMP_RED};
      G2:      pair = {LAMP_RED,    LAMP_GREEN};
      Y2:      pair = {LAMP_RED,    LAMP_YELLOW};
      AR2:     pair = {LAMP_RED,    LAMP_RED};
      FL:      pair = flash_off ? {LAMP_OFF, LAMP_OFF} : {LAMP_YELLOW, LAMP_YELLOW};
      default: pair = {LAMP_RED,    LAMP_RED};
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/semaforo_phase_timer.sv
// semaforo_phase_timer
//   Cycle counter for the current phase.
//   Ports:
//     clk    in  clock
//     rst_n  in  asynchronous active-low reset (cnt -> 0)
//     clear  in  restart counting from 0 on the next edge
//     limit  in  length of the current phase in cycles
//     cnt    out cycles elapsed in the current phase, 0-based
//     done   out high on the last cycle of the phase (cnt == limit-1)
module semaforo_phase_timer import semaforo_pkg::*; #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_r;

  // Phase cycle counter: restart on clear, otherwise count up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

  assign cnt  = cnt_r;
  assign done = (cnt_r == (limit - ONE));

endmodule

// File: rtl/semaforo_scheduler.sv
// semaforo_scheduler
//   Phase scheduler for a two-approach intersection: G1 -> Y1 -> AR1 -> G2 ->
//   Y2 -> AR2 -> G1. A latched request from the waiting approach truncates the
//   opposing green once minimum green has elapsed.
//   Optional feature macro: SEMAFORO_NIGHT_FLASH_EN (night flash phase FL).
//   Ports:
//     clk     in  clock
//     rst_n   in  asynchronous active-low reset
//     req1    in  request green for approach 1 (level, synchronised)
//     req2    in  request green for approach 2 (level, synchronised)
//     night   in  night-mode request (only with SEMAFORO_NIGHT_FLASH_EN)
//     color   out lamp code, approach 1 (registered)
//     color2  out lamp code, approach 2 (registered)
//     phase   out current phase (phase_t encoding)
//     cnt     out cycles elapsed in current phase
//     pend    out latched requests {pend2, pend1}
module semaforo_scheduler import semaforo_pkg::*; #(
  parameter int CW       = 5,
  parameter int T_GREEN  = 8,
  parameter int T_MINGRN = 4,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 1,
  parameter int T_FLASH  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req1,
  input  logic          req2,
  input  logic          night,
  output logic [1:0]    color,
  output logic [1:0]    color2,
  output logic [2:0]    phase,
  output logic [CW-1:0] cnt,
  output logic [1:0]    pend
);

  localparam logic [CW-1:0] LIM_GREEN  = CW'(T_GREEN);
  localparam logic [CW-1:0] LIM_YELLOW = CW'(T_YELLOW);
  localparam logic [CW-1:0] LIM_ALLRED = CW'(T_ALLRED);
  localparam logic [CW-1:0] LIM_FLASH  = CW'(T_FLASH);
  localparam logic [CW-1:0] MINGRN_M1  = CW'(T_MINGRN - 1);

  phase_t        phase_r, next_phase_s;
  logic [1:0]    pend_r, next_pend_s;
  logic          flash_r, next_flash_s;
  logic [1:0]    color_r, color2_r;
  logic [3:0]    lamp_next_s;
  logic [CW-1:0] cnt_s, limit_s;
  logic          done_s, clear_s;
  logic          set1_s, set2_s, clr1_s, clr2_s;

`ifndef SEMAFORO_NIGHT_FLASH_EN
  logic unused_night_s;
  assign unused_night_s = night;
`endif

  semaforo_phase_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_s),
    .limit (limit_s),
    .cnt   (cnt_s),
    .done  (done_s)
  );

  // Length of the phase currently being timed.
  always_comb begin
    limit_s = LIM_ALLRED;
    case (phase_r)
      G1, G2:   limit_s = LIM_GREEN;
      Y1, Y2:   limit_s = LIM_YELLOW;
      AR1, AR2: limit_s = LIM_ALLRED;
      FL:       limit_s = LIM_FLASH;
      default:  limit_s = LIM_ALLRED;
    endcase
  end

  // Next-phase decision, request latching and flash half tracking.
  always_comb begin
    next_phase_s = phase_r;
    case (phase_r)
      G1: begin
        if (done_s || (pend_r[1] && (cnt_s >= MINGRN_M1))) next_phase_s = Y1;
        else next_phase_s = G1;
      end
      Y1: begin
        if (done_s) next_phase_s = AR1;
        else next_phase_s = Y1;
      end
      AR1: begin
        if (done_s) begin
`ifdef SEMAFORO_NIGHT_FLASH_EN
          if (night) next_phase_s = FL;
          else next_phase_s = G2;
`else
          next_phase_s = G2;
`endif
        end else begin
          next_phase_s = AR1;
        end
      end
      G2: begin
        if (done_s || (pend_r[0] && (cnt_s >= MINGRN_M1))) next_phase_s = Y2;
        else next_phase_s = G2;
      end
      Y2: begin
        if (done_s) next_phase_s = AR2;
        else next_phase_s = Y2;
      end
      AR2: begin
        if (done_s) begin
`ifdef SEMAFORO_NIGHT_FLASH_EN
          if (night) next_phase_s = FL;
          else next_phase_s = G1;
`else
          next_phase_s = G1;
`endif
        end else begin
          next_phase_s = AR2;
        end
      end
`ifdef SEMAFORO_NIGHT_FLASH_EN
      FL: begin
        if (!night) next_phase_s = AR2;
        else next_phase_s = FL;
      end
`endif
      // Unknown codes (and FL when the flash feature is absent) recover via AR2.
      default: next_phase_s = AR2;
    endcase

    // Requests latch except during own green and during the night flash;
    // entering own green clears and overrides a same-cycle set.
    set1_s = req1 && (phase_r != G1) && (phase_r != FL);
    set2_s = req2 && (phase_r != G2) && (phase_r != FL);
    clr1_s = (next_phase_s == G1) && (phase_r != G1);
    clr2_s = (next_phase_s == G2) && (phase_r != G2);
    next_pend_s[0] = clr1_s ? 1'b0 : (pend_r[0] | set1_s);
    next_pend_s[1] = clr2_s ? 1'b0 : (pend_r[1] | set2_s);

    // Flash starts in the lit half and flips at every half-period boundary.
    if ((next_phase_s == FL) && (phase_r == FL)) begin
      next_flash_s = flash_r ^ done_s;
    end else begin
      next_flash_s = 1'b0;
    end

    // FL restarts the counter every half-period, other phases only on change.
    clear_s = (next_phase_s != phase_r) || ((phase_r == FL) && done_s);

    lamp_next_s = lamp_pair(next_phase_s, next_flash_s);
  end

  // Phase state, request latches and lamp output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r  <= G1;
      pend_r   <= 2'b00;
      flash_r  <= 1'b0;
      color_r  <= LAMP_GREEN;
      color2_r <= LAMP_RED;
    end else begin
      phase_r  <= next_phase_s;
      pend_r   <= next_pend_s;
      flash_r  <= next_flash_s;
      color_r  <= lamp_next_s[3:2];
      color2_r <= lamp_next_s[1:0];
    end
  end

  assign phase  = phase_r;
  assign cnt    = cnt_s;
  assign pend   = pend_r;
  assign color  = color_r;
  assign color2 = color2_r;

endmodule
